uart_bus_ctrl: RTL and testbench

Processor-side memory-mapped controller for the UART peripheral of the MIPS32 core. It buffers bytes written by software in a TX FIFO and feeds them one at a time into the UART transmitter's `txData`/`txEnable` handshake, pacing on `tx_busy`. It captures each received byte on `rxReady` into an RX FIFO and acknowledges the receiver with a one-cycle `rxClear` pulse. Software sees a DATA register and a STATUS register on the data-memory bus.

---
 rtl/uart_ctrl_pkg.sv | 35 +++
 rtl/uart_sync_fifo.sv | 67 ++++++
 rtl/uart_bus_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_bus_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg
// Shared definitions for the UART bus controller: register addresses,
// STATUS bit positions, FSM state encodings and the TX busy timeout.
// No ports.
package uart_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_IRQ_EN = 2'd2;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_TX_DROP    = 5;
    localparam int ST_TX_ACTIVE  = 6;

    // Cycles spent in WAIT_BUSY before giving up on the transmitter.
    localparam logic [2:0] TX_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LAUNCH,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_ARMED,
        RX_CLEAR,
        RX_WAIT_LOW
    } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Single-clock FIFO with a combinational head output.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wdata       write request and data (ignored when full unless a pop
//                     happens in the same cycle)
//   pop               read request (ignored when empty, so an empty FIFO
//                     with push and pop together only pushes)
//   rdata             current head entry
//   full, empty       occupancy flags
//   count             number of stored entries
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != FULL_CNT) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl
// Memory-mapped UART controller: TX FIFO feeding the UART transmitter, RX FIFO
// capturing received bytes, DATA/STATUS registers on the data-memory bus.
// Optional macro UART_CTRL_IRQ_EN adds an IRQ_EN register at address 2 and a
// registered irq output.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   addr, wr_en, rd_en          register select and one-cycle access strobes
//   wr_data, rd_data            write data (bits [7:0] used), registered read data
//   uart_tx_data/enable/busy    transmitter side
//   uart_rx_ready/data/clear    receiver side
//   irq                         interrupt request (UART_CTRL_IRQ_EN only)
//
// UART handshakes: a byte is offered to the transmitter by a one-cycle
// uart_tx_enable pulse with uart_tx_data stable, only while uart_tx_busy is
// low; the transmitter is then owned until busy rises and falls again (or the
// busy timeout expires). A received byte is valid while uart_rx_ready is high;
// it is taken once on the first ready cycle, acknowledged with a one-cycle
// uart_rx_clear, and no new byte is taken until ready has been seen low.
module uart_bus_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_enable,
    input  logic        uart_tx_busy,
    input  logic        uart_rx_ready,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_clear
`ifdef UART_CTRL_IRQ_EN
    ,
    output logic        irq
`endif
);
    import uart_ctrl_pkg::*;

    tx_state_t tx_state, tx_state_next;
    rx_state_t rx_state, rx_state_next;

    logic [2:0]  tmo_cnt;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [7:0]  tx_head, rx_head;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic        tx_push, tx_pop, rx_push, rx_pop, rx_capture;
    logic        wr_data_acc, wr_status_acc, rd_data_acc;
    logic        tx_drop, rx_overrun, tx_active;
    logic [31:0] status_word;
    logic        unused_bits;

    assign wr_data_acc   = wr_en && (addr == ADDR_DATA);
    assign wr_status_acc = wr_en && (addr == ADDR_STATUS);
    assign rd_data_acc   = rd_en && (addr == ADDR_DATA);

    assign tx_push = wr_data_acc && !tx_full;
    assign rx_pop  = rd_data_acc && !rx_empty;
    // A full RX FIFO still accepts the byte if a DATA read frees a slot now.
    assign rx_push = rx_capture && (!rx_full || rx_pop);
    assign tx_active = (tx_state != TX_IDLE);

    assign unused_bits = ^{wr_data[31:8], tx_count, rx_count};

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .wdata (wr_data[7:0]),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .wdata (uart_rx_data),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // TX FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state     <= TX_IDLE;
            tmo_cnt      <= '0;
            uart_tx_data <= '0;
        end else begin
            tx_state <= tx_state_next;
            tmo_cnt  <= (tx_state == TX_WAIT_BUSY) ? tmo_cnt + 3'd1 : 3'd0;
            if (tx_pop) uart_tx_data <= tx_head;
        end
    end

    always_comb begin
        tx_state_next  = tx_state;
        tx_pop         = 1'b0;
        uart_tx_enable = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && !uart_tx_busy) begin
                    tx_pop        = 1'b1;
                    tx_state_next = TX_LAUNCH;
                end
            end
            TX_LAUNCH: begin
                uart_tx_enable = 1'b1;
                tx_state_next  = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    tx_state_next = TX_WAIT_DONE;
                end else if (tmo_cnt == TX_TIMEOUT - 3'd1) begin
                    tx_state_next = TX_IDLE;
                end
            end
            TX_WAIT_DONE: begin
                if (!uart_tx_busy) tx_state_next = TX_IDLE;
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // RX FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_ARMED;
        end else begin
            rx_state <= rx_state_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_capture    = 1'b0;
        uart_rx_clear = 1'b0;
        case (rx_state)
            RX_ARMED: begin
                if (uart_rx_ready) begin
                    rx_capture    = 1'b1;
                    rx_state_next = RX_CLEAR;
                end
            end
            RX_CLEAR: begin
                uart_rx_clear = 1'b1;
                rx_state_next = RX_WAIT_LOW;
            end
            RX_WAIT_LOW: begin
                if (!uart_rx_ready) rx_state_next = RX_ARMED;
            end
            default: rx_state_next = RX_ARMED;
        endcase
    end

    // Sticky flags: a new event in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_drop    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (wr_data_acc && tx_full) begin
                tx_drop <= 1'b1;
            end else if (wr_status_acc && wr_data[ST_TX_DROP]) begin
                tx_drop <= 1'b0;
            end
            if (rx_capture && rx_full && !rx_pop) begin
                rx_overrun <= 1'b1;
            end else if (wr_status_acc && wr_data[ST_RX_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        status_word                = '0;
        status_word[ST_TX_FULL]    = tx_full;
        status_word[ST_TX_EMPTY]   = tx_empty;
        status_word[ST_RX_EMPTY]   = rx_empty;
        status_word[ST_RX_FULL]    = rx_full;
        status_word[ST_RX_OVERRUN] = rx_overrun;
        status_word[ST_TX_DROP]    = tx_drop;
        status_word[ST_TX_ACTIVE]  = tx_active;
    end

`ifdef UART_CTRL_IRQ_EN
    logic [2:0] irq_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_en && (addr == ADDR_IRQ_EN)) irq_en <= wr_data[2:0];
            irq <= (irq_en[0] && !rx_empty) ||
                   (irq_en[1] && tx_empty && !tx_active) ||
                   (irq_en[2] && rx_overrun);
        end
    end
`endif

    // Read data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            case (addr)
                ADDR_DATA:   rd_data <= rx_empty ? 32'd0 : {24'd0, rx_head};
                ADDR_STATUS: rd_data <= status_word;
`ifdef UART_CTRL_IRQ_EN
                ADDR_IRQ_EN: rd_data <= {29'd0, irq_en};
`endif
                default:     rd_data <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb_uart_bus_ctrl
// Directed-plus-random bench for uart_bus_ctrl with a queue-based reference
// model, a behavioural UART transmitter busy model and a launch monitor.
module tb_uart_bus_ctrl;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic [1:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_enable;
    logic        uart_tx_busy;
    logic        uart_rx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_clear;
`ifdef UART_CTRL_IRQ_EN
    logic        irq;
`endif

    uart_bus_ctrl #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr           (addr),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .wr_data        (wr_data),
        .rd_data        (rd_data),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_enable (uart_tx_enable),
        .uart_tx_busy   (uart_tx_busy),
        .uart_rx_ready  (uart_rx_ready),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_clear  (uart_rx_clear)
`ifdef UART_CTRL_IRQ_EN
        ,
        .irq            (irq)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int tests_run = 0;
    int failed    = 0;

    logic [7:0] exp_q[$];      // bytes the controller accepted, in order
    logic [7:0] got_tx[$];     // bytes seen launched on the UART
    int         launch_cyc[$];
    logic [7:0] rx_q[$];       // reference RX FIFO contents
    int         cyc = 0;
    int         rx_clear_cnt = 0;
    int         launch_busy_err = 0;
    int         busy_mode = 0;  // 0: 10-cycle frames, 1: held busy, 2: never busy
    int         busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch monitor and UART transmitter busy model.
    always @(negedge clk) begin
        cyc++;
        if (rst_n === 1'b1 && uart_tx_enable === 1'b1) begin
            got_tx.push_back(uart_tx_data);
            launch_cyc.push_back(cyc);
            if (uart_tx_busy === 1'b1) launch_busy_err++;
        end
        if (uart_rx_clear === 1'b1) rx_clear_cnt++;
        case (busy_mode)
            0: begin
                if (uart_tx_enable === 1'b1) busy_cnt = 10;
                else if (busy_cnt > 0) busy_cnt--;
                uart_tx_busy = (busy_cnt > 0);
            end
            1: begin
                busy_cnt = 0;
                uart_tx_busy = 1'b1;
            end
            default: begin
                busy_cnt = 0;
                uart_tx_busy = 1'b0;
            end
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        addr = a; wr_data = d; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        addr = a; rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge clk); #1;
        uart_rx_data = b; uart_rx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 uart_rx_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_launches(input int n, input int budget);
        int k = 0;
        while (got_tx.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("launch_wait", got_tx.size(), n);
    endtask

    task automatic compare_tx(input string tag);
        check({tag, "_count"}, got_tx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_tx.size(); i++)
            check({tag, "_byte"}, {24'd0, got_tx[i]}, {24'd0, exp_q[i]});
        got_tx.delete();
        exp_q.delete();
        launch_cyc.delete();
    endtask

    // Software write to DATA with the model's acceptance rule: a byte is
    // accepted only if fewer than DEPTH accepted bytes are still unlaunched.
    task automatic sw_tx_write(input logic [7:0] b, output bit dropped);
        dropped = 1'b0;
        if (exp_q.size() - got_tx.size() < DEPTH) exp_q.push_back(b);
        else dropped = 1'b1;
        bus_write(2'd0, {24'd0, b});
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic [7:0]  b9;
        bit          dr;
        int          op;

        rst_n = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        uart_rx_ready = 1'b0; uart_rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_tx_data", {24'd0, uart_tx_data}, 32'd0);
        check("reset_tx_enable", {31'd0, uart_tx_enable}, 32'd0);
        check("reset_rx_clear", {31'd0, uart_rx_clear}, 32'd0);
        rst_n = 1'b1;
        bus_read(2'd1, d);
        check("reset_status", d, 32'h06);   // tx_empty | rx_empty
        bus_read(2'd3, d);
        check("reserved_read", d, 32'd0);

        // TX basic: launch two cycles after the write, second after busy drops.
        busy_mode = 0;
        sw_tx_write(8'h41, dr);
        check("tx_enable_not_yet", {31'd0, uart_tx_enable}, 32'd0);
        @(posedge clk); #1;
        check("tx_enable_latency", {31'd0, uart_tx_enable}, 32'd1);
        check("tx_data_first", {24'd0, uart_tx_data}, 32'h41);
        @(posedge clk); #1;
        check("tx_enable_one_cycle", {31'd0, uart_tx_enable}, 32'd0);
        sw_tx_write(8'h42, dr);
        wait_launches(2, 100);
        check("launch_while_busy", launch_busy_err, 0);
        repeat (16) @(posedge clk);
        compare_tx("tx_basic");
        bus_read(2'd1, d);
        check("tx_basic_status", d, 32'h06);

        // TX overflow: busy held, nine writes, ninth dropped.
        busy_mode = 1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            sw_tx_write(b, dr);
            if (i == 8) check("tx_ninth_dropped_model", {31'd0, dr}, 32'd1);
        end
        bus_read(2'd1, d);
        check("tx_overflow_status", d, 32'h25);  // tx_full | rx_empty | tx_drop
        bus_write(2'd1, 32'h20);
        bus_read(2'd1, d);
        check("tx_drop_cleared", d, 32'h05);
        busy_mode = 0;
        wait_launches(8, 400);
        repeat (20) @(posedge clk);
        compare_tx("tx_overflow");

        // Timeout: busy never rises; LAUNCH + 4 WAIT_BUSY + IDLE = 6 cycles apart.
        busy_mode = 2;
        repeat (2) @(posedge clk);
        sw_tx_write(8'($urandom), dr);
        sw_tx_write(8'($urandom), dr);
        wait_launches(2, 60);
        if (launch_cyc.size() >= 2)
            check("timeout_gap", launch_cyc[1] - launch_cyc[0], 6);
        repeat (8) @(posedge clk);
        compare_tx("timeout");
        bus_read(2'd1, d);
        check("timeout_status", d, 32'h06);

        // Reset while in WAIT_DONE with three bytes queued.
        busy_mode = 0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) sw_tx_write(8'($urandom_range(1, 255)), dr);
        bus_read(2'd1, d);
        check("mid_frame_status", d, 32'h44);  // rx_empty | tx_active
        rst_n = 1'b0;
        #1;
        check("rst_tx_enable", {31'd0, uart_tx_enable}, 32'd0);
        check("rst_rx_clear", {31'd0, uart_rx_clear}, 32'd0);
        check("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        got_tx.delete(); exp_q.delete(); launch_cyc.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("no_launch_after_reset", got_tx.size(), 0);
        bus_read(2'd1, d);
        check("post_reset_status", d, 32'h06);

        // RX capture: ready held 5 cycles gives one clear pulse and one byte.
        rx_clear_cnt = 0;
        @(posedge clk); #1;
        uart_rx_data = 8'h5A; uart_rx_ready = 1'b1;
        @(posedge clk); #1;
        check("rx_clear_next_cycle", {31'd0, uart_rx_clear}, 32'd1);
        @(posedge clk); #1;
        check("rx_clear_one_cycle", {31'd0, uart_rx_clear}, 32'd0);
        repeat (3) @(posedge clk);
        #1 uart_rx_ready = 1'b0;
        @(posedge clk); #1;
        check("rx_clear_pulses", rx_clear_cnt, 1);
        bus_read(2'd0, d);
        check("rx_read_byte", d, 32'h5A);
        bus_read(2'd0, d);
        check("rx_read_empty", d, 32'd0);
        bus_read(2'd1, d);
        check("rx_empty_status", d, 32'h06);

        // RX overrun: eight fill the FIFO, the ninth is dropped.
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            rx_q.push_back(b);
            rx_byte(b);
        end
        rx_byte(8'($urandom));
        bus_read(2'd1, d);
        check("rx_overrun_status", d, 32'h1A);  // tx_empty | rx_full | rx_overrun
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, d);
        check("rx_overrun_cleared", d, 32'h0A);
        while (rx_q.size() > 0) begin
            bus_read(2'd0, d);
            check("rx_overrun_order", d, {24'd0, rx_q.pop_front()});
        end
        bus_read(2'd1, d);
        check("rx_drained_status", d, 32'h06);

        // RX boundary: ninth arrival in the same cycle as a DATA read.
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            rx_q.push_back(b);
            rx_byte(b);
        end
        b9 = 8'($urandom);
        @(posedge clk); #1;
        uart_rx_data = b9; uart_rx_ready = 1'b1; addr = 2'd0; rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        check("rx_coincide_read", rd_data, {24'd0, rx_q.pop_front()});
        rx_q.push_back(b9);
        @(posedge clk); #1 uart_rx_ready = 1'b0;
        @(posedge clk); #1;
        bus_read(2'd1, d);
        check("rx_coincide_status", d, 32'h0A);
        while (rx_q.size() > 0) begin
            bus_read(2'd0, d);
            check("rx_coincide_order", d, {24'd0, rx_q.pop_front()});
        end
        bus_read(2'd0, d);
        check("rx_coincide_empty", d, 32'd0);

        // Random mix of TX writes, RX arrivals, DATA and STATUS reads.
        busy_mode = 0;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: if (exp_q.size() - got_tx.size() < DEPTH) sw_tx_write(8'($urandom), dr);
                1: if (rx_q.size() < DEPTH) begin
                       b = 8'($urandom);
                       rx_q.push_back(b);
                       rx_byte(b);
                   end
                2: begin
                       bus_read(2'd0, d);
                       if (rx_q.size() > 0) check("rand_rx_data", d, {24'd0, rx_q.pop_front()});
                       else check("rand_rx_data_empty", d, 32'd0);
                   end
                default: begin
                       bus_read(2'd1, d);
                       check("rand_rx_status", d & 32'h1C,
                             ((rx_q.size() == 0) ? 32'h04 : 32'h00) |
                             ((rx_q.size() == DEPTH) ? 32'h08 : 32'h00));
                   end
            endcase
        end
        wait_launches(exp_q.size(), 1000);
        repeat (16) @(posedge clk);
        compare_tx("random_tx");
        while (rx_q.size() > 0) begin
            bus_read(2'd0, d);
            check("rand_rx_drain", d, {24'd0, rx_q.pop_front()});
        end

`ifdef UART_CTRL_IRQ_EN
        bus_write(2'd2, 32'h1);
        bus_read(2'd2, d);
        check("irq_en_readback", d, 32'h1);
        check("irq_idle", {31'd0, irq}, 32'd0);
        b = 8'($urandom);
        rx_byte(b);
        check("irq_rx_pending", {31'd0, irq}, 32'd1);
        bus_read(2'd0, d);
        check("irq_rx_byte", d, {24'd0, b});
        @(posedge clk); #1;
        check("irq_after_read", {31'd0, irq}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
